// File: rtl/bcd_ascii_streamer_pkg.sv
// bcd_ascii_streamer_pkg: ASCII codes and FSM states shared by the BCD-to-ASCII streamer.
package bcd_ascii_streamer_pkg;
    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_ZERO  = 7'h30;
    localparam logic [6:0] ASCII_DOT   = 7'h2E;
    localparam logic [6:0] ASCII_QMARK = 7'h3F;
    typedef enum logic {IDLE, EMIT} state_t;
endpackage

// File: rtl/bcd_ascii_streamer_digit.sv
// bcd_ascii_streamer_digit: combinational BCD nibble to ASCII digit, flagging nibbles above 9.
module bcd_ascii_streamer_digit
    import bcd_ascii_streamer_pkg::*;
#(
    parameter logic [6:0] INVALID_CHAR = ASCII_QMARK
) (
    input  logic [3:0] nibble,
    output logic [6:0] code,
    output logic       err
);
    always_comb begin
        err  = nibble > 4'd9;
        code = err ? INVALID_CHAR : ASCII_ZERO + {3'b000, nibble};
    end
endmodule

// File: rtl/bcd_ascii_streamer.sv
// bcd_ascii_streamer: streams a packed BCD word MSB-first as ASCII characters over valid/ready,
// with optional decimal point, leading-zero blanking and invalid-nibble flagging.
module bcd_ascii_streamer
    import bcd_ascii_streamer_pkg::*;
#(
    parameter int         DIGITS       = 4,
    parameter int         DP_POS       = 2,
    parameter int         BLANK_LZ     = 1,
    parameter logic [6:0] BLANK_CHAR   = ASCII_SPACE,
    parameter logic [6:0] INVALID_CHAR = ASCII_QMARK,
    localparam int        NCHAR        = DIGITS + (DP_POS > 0 ? 1 : 0),
    localparam int        IDXW         = NCHAR > 1 ? $clog2(NCHAR) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd_word,
    input  logic                  bcd_valid,
    output logic                  bcd_ready,
    output logic [6:0]            ascii_char,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  char_last,
    output logic [IDXW-1:0]       char_idx,
    output logic                  char_err
);
    localparam int INTD = DIGITS - DP_POS;

    state_t              state, state_n;
    logic [4*DIGITS-1:0] word_q, src_word;
    logic [DIGITS-1:0]   blank_q, new_mask, src_mask;
    logic [IDXW-1:0]     pos;
    logic [3:0]          nib;
    logic [6:0]          code, next_char;
    logic                code_err, is_dot, blank, next_last, next_err, load, advance, done, lz;
    int                  dig;

    // A digit is blanked while it and every more-significant digit are zero, sparing the integer LSD.
    always_comb begin
        lz       = 1'b1;
        new_mask = '0;
        for (int d = 0; d < DIGITS; d++) begin
            lz          = lz & (bcd_word[4*(DIGITS-1-d) +: 4] == 4'd0);
            new_mask[d] = (BLANK_LZ != 0) && (d < INTD - 1) && lz;
        end
    end

    // In IDLE the first character is built straight from the incoming word so it lands one cycle after capture.
    always_comb begin
        src_word = state == IDLE ? bcd_word : word_q;
        src_mask = state == IDLE ? new_mask : blank_q;
        pos      = state == IDLE ? '0 : char_idx + 1'b1;
        is_dot   = DP_POS > 0 && int'(pos) == INTD;
        dig      = (DP_POS > 0 && int'(pos) > INTD) ? int'(pos) - 1 : int'(pos);
        nib      = '0;
        blank    = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (d == dig) begin
                nib   = src_word[4*(DIGITS-1-d) +: 4];
                blank = src_mask[d];
            end
        end
    end

    bcd_ascii_streamer_digit #(.INVALID_CHAR(INVALID_CHAR)) u_digit (
        .nibble(nib),
        .code  (code),
        .err   (code_err)
    );

    always_comb begin
        next_char = is_dot ? ASCII_DOT : blank ? BLANK_CHAR : code;
        next_err  = ~is_dot & ~blank & code_err;
        next_last = int'(pos) == NCHAR - 1;
        load      = state == IDLE && bcd_valid;
        advance   = state == EMIT && char_ready;
        done      = advance && char_last;
    end

    always_comb begin
        state_n = state;
        if (load) state_n = EMIT;
        else if (done) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        state <= rst ? IDLE : state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q     <= '0;
            blank_q    <= '0;
            char_idx   <= '0;
            ascii_char <= '0;
            char_last  <= 1'b0;
            char_err   <= 1'b0;
        end else if (load || advance) begin
            word_q     <= src_word;
            blank_q    <= src_mask;
            char_idx   <= done ? '0 : pos;
            ascii_char <= done ? '0 : next_char;
            char_last  <= done ? 1'b0 : next_last;
            char_err   <= done ? 1'b0 : next_err;
        end
    end

    assign char_valid = state == EMIT;
    assign bcd_ready  = state == IDLE && !rst;
endmodule
